alu_ctrl_mc: RTL and testbench

//  Parametrised ALU control unit for the multi-cycle CPU datapath. Decodes aluop/funct3/funct7/op into a

---
 rtl/alu_ctrl_pkg.sv | 43 ++++
 rtl/alu_ctrl_mc_md_lat_counter.sv | 38 +++
 rtl/alu_ctrl_mc.sv | 169 ++++++++++++++++
 tb/tb_alu_ctrl_mc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the multi-cycle ALU control unit: ALU operation codes,
// instruction field encodings and the M-op sequencer state type.
package alu_ctrl_pkg;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_SLL    = 5'd2;
   localparam logic [4:0] ALU_SLT    = 5'd3;
   localparam logic [4:0] ALU_SLTU   = 5'd4;
   localparam logic [4:0] ALU_XOR    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_OR     = 5'd8;
   localparam logic [4:0] ALU_AND    = 5'd9;
   localparam logic [4:0] ALU_MUL    = 5'd10;
   localparam logic [4:0] ALU_MULH   = 5'd11;
   localparam logic [4:0] ALU_MULHSU = 5'd12;
   localparam logic [4:0] ALU_MULHU  = 5'd13;
   localparam logic [4:0] ALU_DIV    = 5'd14;
   localparam logic [4:0] ALU_DIVU   = 5'd15;
   localparam logic [4:0] ALU_REM    = 5'd16;
   localparam logic [4:0] ALU_REMU   = 5'd17;

   localparam logic [6:0] OP_RTYPE   = 7'b0110011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_ARITH = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } md_state_e;

   function automatic logic is_md_code(input logic [4:0] code);
      return (code >= ALU_MUL) && (code <= ALU_REMU);
   endfunction

endpackage

// File: rtl/alu_ctrl_mc_md_lat_counter.sv
// Latency down-counter for M-op sequencing: load, clear, saturating decrement
// and a zero flag that tells the sequencer the RUN phase is over.
module md_lat_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clr,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU control for the multi-cycle CPU: combinational RV32I decode plus an
// IDLE/RUN/DONE sequencer that stalls the front end for fixed-latency M-ops.
module alu_ctrl_mc
   import alu_ctrl_pkg::*;
#(
   parameter int CTRL_W   = 5,
   parameter bit ENABLE_M = 1'b1,
   parameter int MUL_LAT  = 4,
   parameter int DIV_LAT  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dec_valid,
   input  logic              flush,
   input  logic [1:0]        aluop,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [6:0]        op,
   output logic [CTRL_W-1:0] alucontrol,
   output logic              is_muldiv,
   output logic              md_start,
   output logic              md_busy,
   output logic              md_done,
   output logic              stall,
   output logic              illegal
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   md_state_e  state_d, state_q;
   logic [4:0] held_ctrl_d, held_ctrl_q;
   logic [4:0] dec_code, ctrl_sel;
   logic       dec_md, dec_ill, is_rtype, start_req;
   logic       cnt_load, cnt_clr, cnt_dec, cnt_zero;
   logic       md_start_c, md_busy_c, md_done_c, stall_c;

   always_comb begin
      dec_code = ALU_ADD;
      dec_md   = 1'b0;
      dec_ill  = 1'b0;
      is_rtype = (op == OP_RTYPE);
      case (aluop)
         ALUOP_MEM: dec_code = ALU_ADD;
         ALUOP_BR: begin
            if (funct3[2:1] == 2'b11)  dec_code = ALU_SLTU;
            else if (funct3[2])        dec_code = ALU_SLT;
            else                       dec_code = ALU_SUB;
         end
         ALUOP_ARITH: begin
            if (is_rtype && (funct7 == F7_MULDIV)) begin
               if (ENABLE_M) begin
                  dec_md = 1'b1;
                  case (funct3)
                     3'b000:  dec_code = ALU_MUL;
                     3'b001:  dec_code = ALU_MULH;
                     3'b010:  dec_code = ALU_MULHSU;
                     3'b011:  dec_code = ALU_MULHU;
                     3'b100:  dec_code = ALU_DIV;
                     3'b101:  dec_code = ALU_DIVU;
                     3'b110:  dec_code = ALU_REM;
                     default: dec_code = ALU_REMU;
                  endcase
               end else begin
                  dec_ill = 1'b1;
               end
            end else if (is_rtype && (funct7 != F7_BASE) && (funct7 != F7_ALT)) begin
               dec_ill = 1'b1;
            end else begin
               // Immediate forms carry no SUB; only register forms (op[5]) do.
               case (funct3)
                  3'b000:  dec_code = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
                  3'b001:  dec_code = ALU_SLL;
                  3'b010:  dec_code = ALU_SLT;
                  3'b011:  dec_code = ALU_SLTU;
                  3'b100:  dec_code = ALU_XOR;
                  3'b101:  dec_code = funct7[5] ? ALU_SRA : ALU_SRL;
                  3'b110:  dec_code = ALU_OR;
                  default: dec_code = ALU_AND;
               endcase
            end
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_code = ALU_ADD;
         dec_md   = 1'b0;
      end
   end

   // rst_n gates the start request so no handshake can be raised while reset is held.
   assign start_req = rst_n && dec_valid && dec_md && !flush;

   always_comb begin
      state_d     = state_q;
      held_ctrl_d = held_ctrl_q;
      ctrl_sel    = dec_code;
      md_start_c  = 1'b0;
      md_busy_c   = 1'b0;
      md_done_c   = 1'b0;
      stall_c     = 1'b0;
      cnt_load    = 1'b0;
      cnt_clr     = 1'b0;
      cnt_dec     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               md_start_c  = 1'b1;
               stall_c     = 1'b1;
               held_ctrl_d = dec_code;
               cnt_load    = 1'b1;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            ctrl_sel  = held_ctrl_q;
            stall_c   = 1'b1;
            md_busy_c = 1'b1;
            if (flush) begin
               cnt_clr = 1'b1;
               state_d = S_IDLE;
            end else if (cnt_zero) begin
               state_d = S_DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_DONE: begin
            ctrl_sel  = held_ctrl_q;
            md_done_c = !flush;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         held_ctrl_q <= ALU_ADD;
      end else begin
         state_q     <= state_d;
         held_ctrl_q <= held_ctrl_d;
      end
   end

   md_lat_counter #(
      .CNT_W (CNT_W)
   ) u_lat_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .clr      (cnt_clr),
      .dec      (cnt_dec),
      .load_val (funct3[2] ? DIV_LOAD : MUL_LOAD),
      .zero     (cnt_zero)
   );

   assign alucontrol = CTRL_W'(ctrl_sel);
   assign is_muldiv  = is_md_code(ctrl_sel);
   assign md_start   = md_start_c;
   assign md_busy    = md_busy_c;
   assign md_done    = md_done_c;
   assign stall      = stall_c;
   assign illegal    = dec_valid && dec_ill;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed bench for alu_ctrl_mc: decode vector table plus hand-written
// multi-cycle sequences (MUL, DIVU, flush, async reset, ENABLE_M=0).
module tb_alu_ctrl_mc;

   logic       clk, rst_n, dec_valid, flush;
   logic [1:0] aluop;
   logic [2:0] funct3;
   logic [6:0] funct7, op;

   logic [4:0] alucontrol, alucontrol_n;
   logic is_muldiv, md_start, md_busy, md_done, stall, illegal;
   logic is_muldiv_n, md_start_n, md_busy_n, md_done_n, stall_n, illegal_n;

   int tests = 0;
   int fails = 0;

   localparam logic [6:0] OPR = 7'b0110011;
   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] F7M = 7'b0000001;

   alu_ctrl_mc #(.CTRL_W(5), .ENABLE_M(1'b1), .MUL_LAT(4), .DIV_LAT(32)) u_m (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .flush(flush),
      .aluop(aluop), .funct3(funct3), .funct7(funct7), .op(op),
      .alucontrol(alucontrol), .is_muldiv(is_muldiv), .md_start(md_start),
      .md_busy(md_busy), .md_done(md_done), .stall(stall), .illegal(illegal)
   );

   alu_ctrl_mc #(.CTRL_W(5), .ENABLE_M(1'b0), .MUL_LAT(4), .DIV_LAT(32)) u_nom (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .flush(flush),
      .aluop(aluop), .funct3(funct3), .funct7(funct7), .op(op),
      .alucontrol(alucontrol_n), .is_muldiv(is_muldiv_n), .md_start(md_start_n),
      .md_busy(md_busy_n), .md_done(md_done_n), .stall(stall_n), .illegal(illegal_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [1:0] aluop;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [6:0] op;
      logic [4:0] ctrl;
      logic       ill;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      tests++;
      if (act !== 32'(exp)) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic dv, input logic [1:0] a, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [6:0] o);
      dec_valid = dv;
      aluop     = a;
      funct3    = f3;
      funct7    = f7;
      op        = o;
   endtask

   int cnt_busy, cnt_stall, cnt_done;

   initial begin
      vecs[0]  = '{2'b00, 3'b010, 7'h00, 7'b0000011, 5'd0, 1'b0};
      vecs[1]  = '{2'b01, 3'b000, 7'h00, 7'b1100011, 5'd1, 1'b0};
      vecs[2]  = '{2'b01, 3'b100, 7'h00, 7'b1100011, 5'd3, 1'b0};
      vecs[3]  = '{2'b01, 3'b101, 7'h00, 7'b1100011, 5'd3, 1'b0};
      vecs[4]  = '{2'b01, 3'b110, 7'h00, 7'b1100011, 5'd4, 1'b0};
      vecs[5]  = '{2'b10, 3'b000, 7'h20, OPR,        5'd1, 1'b0};
      vecs[6]  = '{2'b10, 3'b000, 7'h20, OPI,        5'd0, 1'b0};
      vecs[7]  = '{2'b10, 3'b001, 7'h00, OPR,        5'd2, 1'b0};
      vecs[8]  = '{2'b10, 3'b010, 7'h00, OPR,        5'd3, 1'b0};
      vecs[9]  = '{2'b10, 3'b011, 7'h00, OPR,        5'd4, 1'b0};
      vecs[10] = '{2'b10, 3'b100, 7'h00, OPR,        5'd5, 1'b0};
      vecs[11] = '{2'b10, 3'b101, 7'h00, OPR,        5'd6, 1'b0};
      vecs[12] = '{2'b10, 3'b101, 7'h20, OPI,        5'd7, 1'b0};
      vecs[13] = '{2'b10, 3'b110, 7'h00, OPR,        5'd8, 1'b0};
      vecs[14] = '{2'b10, 3'b111, 7'h00, OPR,        5'd9, 1'b0};
      vecs[15] = '{2'b11, 3'b000, 7'h00, OPR,        5'd0, 1'b1};
      vecs[16] = '{2'b10, 3'b000, 7'h02, OPR,        5'd0, 1'b1};

      rst_n = 1'b0;
      flush = 1'b0;
      set_in(1'b0, 2'b00, 3'b000, 7'h00, 7'h00);
      #12;
      chk("rst_md_start", md_start, 0);
      chk("rst_md_busy", md_busy, 0);
      chk("rst_md_done", md_done, 0);
      chk("rst_stall", stall, 0);
      chk("rst_alucontrol", alucontrol, 0);
      chk("rst_illegal", illegal, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // decode table, all single-cycle or illegal
      for (int i = 0; i < 17; i++) begin
         set_in(1'b1, vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].op);
         #1;
         chk($sformatf("vec%0d_ctrl", i), alucontrol, int'(vecs[i].ctrl));
         chk($sformatf("vec%0d_illegal", i), illegal, int'(vecs[i].ill));
         chk($sformatf("vec%0d_start", i), md_start, 0);
         chk($sformatf("vec%0d_stall", i), stall, 0);
         chk($sformatf("vec%0d_is_md", i), is_muldiv, 0);
         tick();
      end

      // MUL: start c0, stall c0..c4, done c5, held code despite field change
      set_in(1'b1, 2'b10, 3'b000, F7M, OPR);
      #1;
      chk("mul_c0_start", md_start, 1);
      chk("mul_c0_stall", stall, 1);
      chk("mul_c0_ctrl", alucontrol, 10);
      chk("mul_c0_is_md", is_muldiv, 1);
      tick();
      set_in(1'b0, 2'b10, 3'b111, 7'h00, OPR);
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk($sformatf("mul_c%0d_stall", c), stall, 1);
         chk($sformatf("mul_c%0d_busy", c), md_busy, 1);
         chk($sformatf("mul_c%0d_ctrl", c), alucontrol, 10);
         chk($sformatf("mul_c%0d_done", c), md_done, 0);
         tick();
      end
      #1;
      chk("mul_c5_done", md_done, 1);
      chk("mul_c5_stall", stall, 0);
      chk("mul_c5_busy", md_busy, 0);
      chk("mul_c5_ctrl", alucontrol, 10);
      tick();
      #1;
      chk("mul_c6_done", md_done, 0);
      chk("mul_c6_ctrl", alucontrol, 9);

      // DIVU: 32 busy cycles, done c33; DIV in DONE ignored, restarts c34
      set_in(1'b1, 2'b10, 3'b101, F7M, OPR);
      #1;
      chk("divu_c0_start", md_start, 1);
      chk("divu_c0_ctrl", alucontrol, 15);
      tick();
      set_in(1'b0, 2'b00, 3'b000, 7'h00, 7'h00);
      cnt_busy  = 0;
      cnt_stall = 0;
      for (int c = 1; c <= 32; c++) begin
         #1;
         cnt_busy  += int'(md_busy);
         cnt_stall += int'(stall);
         tick();
      end
      chk("divu_busy_cycles", 32'(cnt_busy), 32);
      chk("divu_stall_cycles", 32'(cnt_stall), 32);
      set_in(1'b1, 2'b10, 3'b100, F7M, OPR);
      #1;
      chk("divu_c33_done", md_done, 1);
      chk("divu_c33_no_start", md_start, 0);
      chk("divu_c33_ctrl", alucontrol, 15);
      tick();
      #1;
      chk("div_c34_start", md_start, 1);
      chk("div_c34_ctrl", alucontrol, 14);
      tick();
      set_in(1'b0, 2'b00, 3'b000, 7'h00, 7'h00);
      #1;
      chk("div_c1_busy", md_busy, 1);
      tick();
      flush = 1'b1;
      #1;
      chk("div_c2_busy", md_busy, 1);
      tick();
      flush = 1'b0;
      #1;
      chk("flush_c3_busy", md_busy, 0);
      chk("flush_c3_stall", stall, 0);
      cnt_done = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         cnt_done += int'(md_done);
      end
      chk("flush_no_done", 32'(cnt_done), 0);

      // flush in IDLE suppresses the start
      set_in(1'b1, 2'b10, 3'b000, F7M, OPR);
      flush = 1'b1;
      #1;
      chk("idle_flush_start", md_start, 0);
      chk("idle_flush_stall", stall, 0);
      tick();
      #1;
      chk("idle_flush_busy", md_busy, 0);
      flush = 1'b0;
      set_in(1'b0, 2'b00, 3'b000, 7'h00, 7'h00);
      tick();

      // async reset at c3 of a MUL
      set_in(1'b1, 2'b10, 3'b000, F7M, OPR);
      #1;
      chk("rmul_c0_start", md_start, 1);
      tick();
      set_in(1'b0, 2'b10, 3'b000, F7M, OPR);
      tick();
      tick();
      set_in(1'b1, 2'b10, 3'b011, F7M, OPR);
      #1;
      chk("rmul_c3_busy_pre", md_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rmul_rst_stall", stall, 0);
      chk("rmul_rst_busy", md_busy, 0);
      chk("rmul_rst_start", md_start, 0);
      chk("rmul_rst_done", md_done, 0);
      chk("rmul_rst_ctrl", alucontrol, 13);
      chk("rmul_rst_is_md", is_muldiv, 1);
      tick();
      @(negedge clk);
      set_in(1'b0, 2'b00, 3'b000, 7'h00, 7'h00);
      rst_n = 1'b1;
      tick();
      #1;
      chk("rmul_post_busy", md_busy, 0);
      chk("rmul_post_stall", stall, 0);
      cnt_done = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         cnt_done += int'(md_done);
      end
      chk("rmul_post_no_done", 32'(cnt_done), 0);

      // ENABLE_M=0 instance
      set_in(1'b1, 2'b10, 3'b000, F7M, OPR);
      #1;
      chk("nom_mul_illegal", illegal_n, 1);
      chk("nom_mul_ctrl", alucontrol_n, 0);
      chk("nom_mul_start", md_start_n, 0);
      chk("nom_mul_stall", stall_n, 0);
      chk("nom_mul_is_md", is_muldiv_n, 0);
      set_in(1'b0, 2'b10, 3'b000, F7M, OPR);
      #1;
      chk("nom_ill_gated", illegal_n, 0);
      set_in(1'b1, 2'b11, 3'b000, 7'h00, OPR);
      #1;
      chk("nom_aluop11_illegal", illegal_n, 1);
      tick();
      #1;
      chk("nom_busy_after", md_busy_n, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
